// File: rtl/vxe_txn_pkg.sv
// ----------------------------------------------------------------------------
// vxe_txn_pkg
// Shared definitions for the txn request/response codec blocks:
//   - field offsets and widths of the request data vector {ben, data}
//   - beat-tag flag record and the tagged beat record for the default geometry
//   - input-side burst FSM state encoding
// ----------------------------------------------------------------------------
package vxe_txn_pkg;

  localparam int TXN_DATA_W  = 64;
  localparam int TXN_BLEN_W  = 4;
  localparam int TXN_BEN_W   = TXN_DATA_W / 8;
  localparam int TAG_FLAGS_W = 3;

  // Byte enables sit directly above the data field.
  function automatic int ben_off(input int data_w);
    return data_w;
  endfunction

  function automatic int ben_width(input int data_w);
    return data_w / 8;
  endfunction

  // Width of one tagged beat {ben, data, beat, first, last, nullb}.
  function automatic int tagged_beat_w(input int data_w, input int blen_w);
    return ben_width(data_w) + data_w + blen_w + TAG_FLAGS_W;
  endfunction

  typedef struct packed {
    logic first;
    logic last;
    logic nullb;
  } txn_flags_t;

  typedef struct packed {
    logic [TXN_BEN_W-1:0]  ben;
    logic [TXN_DATA_W-1:0] data;
    logic [TXN_BLEN_W-1:0] beat;
    txn_flags_t            flags;
  } txn_beat_t;

  typedef enum logic {
    TXN_IDLE  = 1'b0,
    TXN_BURST = 1'b1
  } txn_st_e;

endpackage

// File: rtl/vxe_skid_buf.sv
// ----------------------------------------------------------------------------
// vxe_skid_buf
// Two-entry valid/ready skid buffer with a generic payload. The main entry
// drives the outputs; the skid entry catches the one beat accepted while the
// main entry is stalled. in_rdy is the inverse of the registered skid valid,
// so there is no combinational path from out_rdy to in_rdy.
//
// Ports:
//   clk, nrst         clock, asynchronous active-low reset
//   in_dat/in_vld     upstream payload and valid
//   in_rdy            upstream ready (registered)
//   out_dat/out_vld   downstream payload and valid (main entry)
//   out_rdy           downstream ready
// ----------------------------------------------------------------------------
module vxe_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_vld,
  input  logic              out_rdy
);

  logic              main_vld_p1;
  logic [DATA_W-1:0] main_dat_p1;
  logic              skid_vld_p1;
  logic [DATA_W-1:0] skid_dat_p1;
  logic              acc;
  logic              pop;

  assign in_rdy  = ~skid_vld_p1;
  assign acc     = in_vld & in_rdy;
  assign pop     = main_vld_p1 & out_rdy;
  assign out_vld = main_vld_p1;
  assign out_dat = main_dat_p1;

  // ---- stage p1: main / skid entries ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      main_vld_p1 <= 1'b0;
      main_dat_p1 <= '0;
      skid_vld_p1 <= 1'b0;
      skid_dat_p1 <= '0;
    end else if (pop) begin
      if (skid_vld_p1) begin
        // in_rdy is low here, so no accept can collide with the refill
        main_dat_p1 <= skid_dat_p1;
        skid_vld_p1 <= 1'b0;
      end else if (acc) begin
        main_dat_p1 <= in_dat;
      end else begin
        main_vld_p1 <= 1'b0;
      end
    end else if (acc) begin
      if (!main_vld_p1) begin
        main_vld_p1 <= 1'b1;
        main_dat_p1 <= in_dat;
      end else begin
        skid_vld_p1 <= 1'b1;
        skid_dat_p1 <= in_dat;
      end
    end
  end

endmodule

// File: rtl/vxe_txnreqd_unpacker.sv
// ----------------------------------------------------------------------------
// vxe_txnreqd_unpacker
// Splits each request data vector into write data and byte enables and tags
// every beat with its burst position, then registers it through a 2-entry
// skid buffer (1-cycle latency, full rate).
//
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   i_req_vec_dat    {ben, data} request vector
//   i_vld / o_rdy    input handshake
//   i_blen           burst beats minus 1, sampled on the first beat only
//   o_data / o_ben   decoded write data and byte enables
//   o_beat           0-based beat index within the burst
//   o_first/o_last   burst position flags
//   o_nullb          byte enables are all zero
//   o_vld / i_rdy    output handshake
// ----------------------------------------------------------------------------
module vxe_txnreqd_unpacker
  import vxe_txn_pkg::*;
#(
  parameter  int DATA_W = 64,
  localparam int BEN_W  = ben_width(DATA_W),
  parameter  int BLEN_W = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [DATA_W+BEN_W-1:0] i_req_vec_dat,
  input  logic                    i_vld,
  output logic                    o_rdy,
  input  logic [BLEN_W-1:0]       i_blen,
  output logic [DATA_W-1:0]       o_data,
  output logic [BEN_W-1:0]        o_ben,
  output logic [BLEN_W-1:0]       o_beat,
  output logic                    o_first,
  output logic                    o_last,
  output logic                    o_nullb,
  output logic                    o_vld,
  input  logic                    i_rdy
);

  localparam int BEN_OFF = ben_off(DATA_W);
  localparam int PAY_W   = tagged_beat_w(DATA_W, BLEN_W);

  txn_st_e             st_q, st_d;
  logic [BLEN_W-1:0]   cnt_q, cnt_d;
  logic [BLEN_W-1:0]   blen_q, blen_d;
  logic                acc;

  logic [DATA_W-1:0]   data_p0;
  logic [BEN_W-1:0]    ben_p0;
  logic [BLEN_W-1:0]   beat_p0;
  txn_flags_t          flags_p0;
  logic [PAY_W-1:0]    pay_p0;

  logic [PAY_W-1:0]    pay_p1;
  txn_flags_t          flags_p1;

  assign acc     = i_vld & o_rdy;
  assign data_p0 = i_req_vec_dat[0 +: DATA_W];
  assign ben_p0  = i_req_vec_dat[BEN_OFF +: BEN_W];

  // ---- stage p0: combinational beat tagging and burst FSM ----
  always_comb begin
    st_d           = st_q;
    cnt_d          = cnt_q;
    blen_d         = blen_q;
    beat_p0        = '0;
    flags_p0.first = 1'b0;
    flags_p0.last  = 1'b0;
    flags_p0.nullb = ~|ben_p0;
    case (st_q)
      TXN_IDLE: begin
        flags_p0.first = 1'b1;
        flags_p0.last  = (i_blen == '0);
        if (acc) begin
          blen_d = i_blen;
          if (i_blen != '0) begin
            cnt_d = BLEN_W'(1);
            st_d  = TXN_BURST;
          end
        end
      end
      TXN_BURST: begin
        // blen_q is held for the whole burst; i_blen is ignored here
        beat_p0       = cnt_q;
        flags_p0.last = (cnt_q == blen_q);
        if (acc) begin
          if (flags_p0.last) begin
            st_d  = TXN_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + BLEN_W'(1);
          end
        end
      end
      default: begin
        st_d  = TXN_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q   <= TXN_IDLE;
      cnt_q  <= '0;
      blen_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      blen_q <= blen_d;
    end
  end

  assign pay_p0 = {ben_p0, data_p0, beat_p0, flags_p0};

  // ---- stage p1: registered output through the skid buffer ----
  vxe_skid_buf #(
    .DATA_W (PAY_W)
  ) u_skid (
    .clk     (clk),
    .nrst    (nrst),
    .in_dat  (pay_p0),
    .in_vld  (i_vld),
    .in_rdy  (o_rdy),
    .out_dat (pay_p1),
    .out_vld (o_vld),
    .out_rdy (i_rdy)
  );

  assign {o_ben, o_data, o_beat, flags_p1} = pay_p1;
  assign o_first = flags_p1.first;
  assign o_last  = flags_p1.last;
  assign o_nullb = flags_p1.nullb;

endmodule

// File: tb/tb_vxe_txnreqd_unpacker.sv
module tb_vxe_txnreqd_unpacker;

  localparam int DATA_W = 64;
  localparam int BEN_W  = 8;
  localparam int BLEN_W = 4;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic [DATA_W+BEN_W-1:0] i_req_vec_dat;
  logic                    i_vld;
  logic                    o_rdy;
  logic [BLEN_W-1:0]       i_blen;
  logic [DATA_W-1:0]       o_data;
  logic [BEN_W-1:0]        o_ben;
  logic [BLEN_W-1:0]       o_beat;
  logic                    o_first;
  logic                    o_last;
  logic                    o_nullb;
  logic                    o_vld;
  logic                    i_rdy;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  vxe_txnreqd_unpacker #(
    .DATA_W (DATA_W),
    .BLEN_W (BLEN_W)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .i_req_vec_dat (i_req_vec_dat),
    .i_vld         (i_vld),
    .o_rdy         (o_rdy),
    .i_blen        (i_blen),
    .o_data        (o_data),
    .o_ben         (o_ben),
    .o_beat        (o_beat),
    .o_first       (o_first),
    .o_last        (o_last),
    .o_nullb       (o_nullb),
    .o_vld         (o_vld),
    .i_rdy         (i_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d, input logic [7:0] ben,
                          input logic [3:0] beat, input logic first, input logic last,
                          input logic nullb);
    chk({tag, ".vld"},   64'(o_vld),   64'd1);
    chk({tag, ".data"},  o_data,       d);
    chk({tag, ".ben"},   64'(o_ben),   64'(ben));
    chk({tag, ".beat"},  64'(o_beat),  64'(beat));
    chk({tag, ".first"}, 64'(o_first), 64'(first));
    chk({tag, ".last"},  64'(o_last),  64'(last));
    chk({tag, ".nullb"}, 64'(o_nullb), 64'(nullb));
  endtask

  task automatic put(input logic v, input logic [7:0] ben, input logic [63:0] d,
                     input logic [3:0] bl);
    i_vld         = v;
    i_req_vec_dat = {ben, d};
    i_blen        = bl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst  = 1'b0;
    i_rdy = 1'b1;
    put(1'b0, 8'h00, 64'h0, 4'd0);

    // reset state
    tick;
    tick;
    chk("rst.vld",   64'(o_vld),   64'd0);
    chk("rst.rdy",   64'(o_rdy),   64'd1);
    chk("rst.data",  o_data,       64'd0);
    chk("rst.ben",   64'(o_ben),   64'd0);
    chk("rst.beat",  64'(o_beat),  64'd0);
    chk("rst.first", 64'(o_first), 64'd0);
    chk("rst.last",  64'(o_last),  64'd0);
    chk("rst.nullb", 64'(o_nullb), 64'd0);
    nrst = 1'b1;
    tick;

    // single-beat burst
    put(1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 4'd0);
    tick;
    chk_beat("single", 64'h0123_4567_89AB_CDEF, 8'hFF, 4'd0, 1'b1, 1'b1, 1'b0);
    put(1'b0, 8'h00, 64'h0, 4'd0);
    tick;
    chk("single.idle", 64'(o_vld), 64'd0);

    // 4-beat burst; i_blen changes after beat 0 must be ignored
    for (int k = 0; k < 4; k++) begin
      put(1'b1, 8'h0F, 64'h1000 + 64'(k), (k == 0) ? 4'd3 : 4'd7);
      tick;
      chk_beat($sformatf("b4_%0d", k), 64'h1000 + 64'(k), 8'h0F, 4'(k),
               k == 0, k == 3, 1'b0);
    end
    put(1'b0, 8'h00, 64'h0, 4'd0);
    tick;
    chk("b4.idle", 64'(o_vld), 64'd0);

    // backpressure: 3-beat burst with downstream stalled
    i_rdy = 1'b0;
    put(1'b1, 8'hF0, 64'hAAAA, 4'd2);
    tick;
    chk_beat("bp.a0", 64'hAAAA, 8'hF0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("bp.rdy0", 64'(o_rdy), 64'd1);
    put(1'b1, 8'hF0, 64'hBBBB, 4'd0);
    tick;
    chk("bp.rdy1", 64'(o_rdy), 64'd0);
    chk_beat("bp.hold1", 64'hAAAA, 8'hF0, 4'd0, 1'b1, 1'b0, 1'b0);
    put(1'b1, 8'hF0, 64'hCCCC, 4'd0);
    tick;
    chk("bp.rdy2", 64'(o_rdy), 64'd0);
    chk_beat("bp.hold2", 64'hAAAA, 8'hF0, 4'd0, 1'b1, 1'b0, 1'b0);
    i_rdy = 1'b1;
    tick;
    chk_beat("bp.b1", 64'hBBBB, 8'hF0, 4'd1, 1'b0, 1'b0, 1'b0);
    chk("bp.rdy3", 64'(o_rdy), 64'd1);
    tick;
    chk_beat("bp.b2", 64'hCCCC, 8'hF0, 4'd2, 1'b0, 1'b1, 1'b0);
    put(1'b0, 8'h00, 64'h0, 4'd0);
    tick;
    chk("bp.idle", 64'(o_vld), 64'd0);

    // maximum burst: 16 beats
    for (int k = 0; k < 16; k++) begin
      put(1'b1, 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(k), (k == 0) ? 4'd15 : 4'd0);
      tick;
      chk_beat($sformatf("max_%0d", k), 64'hA5A5_0000_0000_0000 | 64'(k), 8'hFF,
               4'(k), k == 0, k == 15, 1'b0);
    end

    // null and single-byte enables, each a fresh single-beat burst
    put(1'b1, 8'h00, 64'hDEAD_BEEF_0000_0001, 4'd0);
    tick;
    chk_beat("null", 64'hDEAD_BEEF_0000_0001, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1);
    put(1'b1, 8'h01, 64'h0000_0000_0000_00FF, 4'd0);
    tick;
    chk_beat("ben01", 64'h0000_0000_0000_00FF, 8'h01, 4'd0, 1'b1, 1'b1, 1'b0);
    put(1'b0, 8'h00, 64'h0, 4'd0);
    tick;

    // reset mid-burst with the skid entry full
    i_rdy = 1'b0;
    put(1'b1, 8'hFF, 64'hB000, 4'd3);
    tick;
    put(1'b1, 8'hFF, 64'hB001, 4'd3);
    tick;
    chk("mr.rdy", 64'(o_rdy), 64'd0);
    chk_beat("mr.hold", 64'hB000, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    put(1'b1, 8'hFF, 64'hB002, 4'd3);
    #2;
    nrst = 1'b0;
    #1;
    chk("mr.vld",  64'(o_vld),  64'd0);
    chk("mr.rdy1", 64'(o_rdy),  64'd1);
    chk("mr.data", o_data,      64'd0);
    #1;
    nrst  = 1'b1;
    i_rdy = 1'b1;
    put(1'b1, 8'hFF, 64'hC000, 4'd1);
    tick;
    chk_beat("mr.c0", 64'hC000, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    put(1'b1, 8'hFF, 64'hC001, 4'd3);
    tick;
    chk_beat("mr.c1", 64'hC001, 8'hFF, 4'd1, 1'b0, 1'b1, 1'b0);
    put(1'b0, 8'h00, 64'h0, 4'd0);
    tick;
    chk("mr.idle", 64'(o_vld), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
